// File: rtl/stopwatch_display.sv
// Stopwatch time display: binary min:sec to BCD via a double-dabble FSM,
// then four-digit time-multiplexed seven-segment drive.
module stopwatch_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] minutes,
  input  logic [5:0] seconds,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [6:0]  last_min_q, last_min_d;
  logic [5:0]  last_sec_q, last_sec_d;
  logic [14:0] min_sr_q, min_sr_d;
  logic [14:0] sec_sr_q, sec_sr_d;
  logic [3:0]  d0_q, d0_d;
  logic [3:0]  d1_q, d1_d;
  logic [3:0]  d2_q, d2_d;
  logic [3:0]  d3_q, d3_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic        blank_q, blank_d;

  logic [6:0]  min_cap;
  logic [5:0]  sec_cap;
  logic [3:0]  digit;

  // {bcd_tens, bcd_ones, binary}: adjust nibbles then shift left one
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign min_cap = (minutes > 7'd99) ? 7'd99 : minutes;
  assign sec_cap = (seconds > 6'd59) ? 6'd59 : seconds;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_min_d = last_min_q;
    last_sec_d = last_sec_q;
    min_sr_d   = min_sr_q;
    sec_sr_d   = sec_sr_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    d3_d       = d3_q;
    blank_d    = blank;
    div_d      = div_q + 1'b1;
    idx_d      = idx_q;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
    case (state_q)
      IDLE: begin
        if ({minutes, seconds} != {last_min_q, last_sec_q}) begin
          last_min_d = minutes;
          last_sec_d = seconds;
          min_sr_d   = {8'd0, min_cap};
          sec_sr_d   = {9'd0, sec_cap};
          step_d     = 3'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        min_sr_d = dd_step(min_sr_q);
        sec_sr_d = dd_step(sec_sr_q);
        step_d   = step_q + 3'd1;
        if (step_q == 3'd6) state_d = COMMIT;
      end
      COMMIT: begin
        d0_d    = sec_sr_q[10:7];
        d1_d    = sec_sr_q[14:11];
        d2_d    = min_sr_q[10:7];
        d3_d    = min_sr_q[14:11];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    blank_q <= blank_d;
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      last_min_q <= '0;
      last_sec_q <= '0;
      min_sr_q   <= '0;
      sec_sr_q   <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      div_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      last_min_q <= last_min_d;
      last_sec_q <= last_sec_d;
      min_sr_q   <= min_sr_d;
      sec_sr_q   <= sec_sr_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      d3_q       <= d3_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    digit = d0_q;
    case (idx_q)
      2'd0: digit = d0_q;
      2'd1: digit = d1_q;
      2'd2: digit = d2_q;
      2'd3: digit = d3_q;
      default: digit = d0_q;
    endcase
  end

  assign seg       = blank_q ? 7'b1111111 : enc(digit);
  assign an        = blank_q ? 4'b1111 : ~(4'b0001 << idx_q);
  assign dp        = blank_q | (idx_q != 2'd2);
  assign conv_busy = (state_q != IDLE);

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: stimulus pushes expected committed digits,
// a monitor checks the multiplexed display and conversion length.
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cur = 16'h0000;
  logic [6:0]  seg_tab [10];

  logic       armed = 1'b0;
  logic       rst_r = 1'b0;
  logic       blank_r = 1'b0;
  logic [1:0] m_div = 2'd0;
  logic [1:0] m_idx = 2'd0;
  logic       busy_prev = 1'b0;
  int         busy_len = 0;

  stopwatch_display #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .minutes(minutes),
    .seconds(seconds),
    .blank(blank),
    .seg(seg),
    .dp(dp),
    .an(an),
    .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000;
    seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001;
    seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010;
    seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  // Reference scan position and registered blank/reset view
  always @(posedge clk) begin
    blank_r <= blank;
    rst_r   <= rst;
    if (rst) begin
      m_div <= 2'd0;
      m_idx <= 2'd0;
      armed <= 1'b1;
    end else if (m_div == 2'd3) begin
      m_div <= 2'd0;
      m_idx <= m_idx + 2'd1;
    end else begin
      m_div <= m_div + 2'd1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [3:0] dv;
      if (rst_r) begin
        cur = 16'h0000;
        chk("busy_in_rst", {31'd0, conv_busy}, 32'd0);
        busy_len = 0;
      end else if (busy_prev && !conv_busy) begin
        chk("busy_len", busy_len, 32'd8);
        chk("commit_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        busy_len = 0;
      end
      if (conv_busy) busy_len++;
      busy_prev = conv_busy;
      if (blank_r) begin
        chk("an_blank", {28'd0, an}, 32'hf);
        chk("seg_blank", {25'd0, seg}, 32'h7f);
        chk("dp_blank", {31'd0, dp}, 32'd1);
      end else begin
        dv = cur[m_idx*4 +: 4];
        chk("an_scan", {28'd0, an}, {28'd0, ~(4'b0001 << m_idx)});
        chk("seg_digit", {25'd0, seg}, {25'd0, seg_tab[dv]});
        chk("dp_sep", {31'd0, dp}, {31'd0, m_idx != 2'd2});
      end
    end
  end

  initial begin
    rst = 1'b1;
    minutes = 7'd0;
    seconds = 6'd0;
    blank = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // a) 00:00 after reset: no conversion, full scan visible
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_no_conv", {31'd0, conv_busy}, 32'd0);
    end

    // b) 12:34
    exp_q.push_back(16'h1234);
    minutes = 7'd12;
    seconds = 6'd34;
    repeat (30) tick();

    // c) saturation and no retrigger on held out-of-range input
    exp_q.push_back(16'h9959);
    minutes = 7'd127;
    seconds = 6'd63;
    repeat (12) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_no_retrig", {31'd0, conv_busy}, 32'd0);
    end

    // d) change mid-conversion, second conversion follows
    exp_q.push_back(16'h5959);
    exp_q.push_back(16'h6000);
    minutes = 7'd59;
    seconds = 6'd59;
    repeat (4) tick();
    minutes = 7'd60;
    seconds = 6'd0;
    repeat (40) tick();

    // e) reset aborts a 45:07 conversion, then it restarts
    minutes = 7'd45;
    seconds = 6'd7;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", {31'd0, conv_busy}, 32'd0);
    chk("abort_an", {28'd0, an}, 32'he);
    chk("abort_seg", {25'd0, seg}, 32'h40);
    exp_q.push_back(16'h4507);
    rst = 1'b0;
    repeat (30) tick();

    // f) blank mid-scan, scan continues underneath
    repeat (2) tick();
    blank = 1'b1;
    repeat (7) tick();
    blank = 1'b0;
    repeat (20) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
